dino_jump_ctrl: RTL and testbench

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

---
 rtl/dino_jump_ctrl.sv | 151 +++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
// Dino runner jump controller: button edge detect, GROUND/RISE/FALL height
// trajectory advanced on frame ticks, and a registered obstacle-overlap flag.
module dino_jump_ctrl #(
  parameter int unsigned APEX   = 48,
  parameter int unsigned STEP   = 2,
  parameter int unsigned DINO_X = 40,
  parameter int unsigned DINO_W = 20,
  parameter int unsigned DINO_H = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn,
  input  logic [1:0] game_state,
  input  logic [9:0] obs_x,
  input  logic [5:0] obs_w,
  input  logic [5:0] obs_h,
  output logic       jump,
  output logic [7:0] dino_y,
  output logic       airborne,
  output logic       collided
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 8;

  localparam logic [1:0] S_GROUND = 2'd0;
  localparam logic [1:0] S_RISE   = 2'd1;
  localparam logic [1:0] S_FALL   = 2'd2;

  localparam logic [1:0] GS_PLAY = 2'b10;
  localparam logic [1:0] GS_DEAD = 2'b01;

  localparam logic [XW-1:0] DINO_L = XW'(DINO_X);
  localparam logic [XW-1:0] DINO_R = XW'(DINO_X + DINO_W - 1);
  localparam logic [YW:0]   APEX_W = (YW + 1)'(APEX);
  localparam logic [YW-1:0] APEX_Y = YW'(APEX);
  localparam logic [YW:0]   STEP_W = (YW + 1)'(STEP);
  localparam logic [YW-1:0] STEP_Y = YW'(STEP);

  if (STEP == 0 || APEX > 255 || DINO_H == 0 || DINO_W == 0 ||
      DINO_X + DINO_W > 1024) begin : g_bad_params
    $error("dino_jump_ctrl: unsupported parameter combination");
  end

  logic [1:0]    state_q, state_d;
  logic [YW-1:0] y_q, y_d;
  logic          btn_q;
  logic          armed_q;
  logic          jump_q;
  logic          collided_q;

  logic          btn_edge;
  logic [YW:0]   y_up;
  logic [XW-1:0] obs_l;
  logic [XW-1:0] obs_r;
  logic          overlap;

  // Edge requires btn to have been seen low since reset, so a button held
  // through reset release never fires.
  assign btn_edge = btn & ~btn_q & armed_q;
  assign y_up     = (YW + 1)'(y_q) + STEP_W;

  // Button history, jump pulse and collision flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q      <= 1'b0;
      armed_q    <= 1'b0;
      jump_q     <= 1'b0;
      collided_q <= 1'b0;
    end else begin
      btn_q      <= btn;
      armed_q    <= armed_q | ~btn;
      jump_q     <= btn_edge;
      collided_q <= overlap & (game_state == GS_PLAY);
    end
  end

  // Jump FSM state and height registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_GROUND;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  // Next-state: only in-game advances; dead freezes; anything else grounds.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    case (game_state)
      GS_PLAY: begin
        case (state_q)
          S_GROUND: begin
            y_d = '0;
            if (btn_edge) begin
              state_d = S_RISE;
            end
          end
          S_RISE: begin
            if (tick) begin
              if (y_up >= APEX_W) begin
                y_d     = APEX_Y;
                state_d = S_FALL;
              end else begin
                y_d = y_up[YW-1:0];
              end
            end
          end
          S_FALL: begin
            if (tick) begin
              if (y_q <= STEP_Y) begin
                y_d     = '0;
                state_d = S_GROUND;
              end else begin
                y_d = y_q - STEP_Y;
              end
            end
          end
          default: begin
            state_d = S_GROUND;
            y_d     = '0;
          end
        endcase
      end
      GS_DEAD: begin
        state_d = state_q;
        y_d     = y_q;
      end
      default: begin
        state_d = S_GROUND;
        y_d     = '0;
      end
    endcase
  end

  // Widened x extents so obstacle right edge cannot wrap near the screen end.
  assign obs_l   = XW'(obs_x);
  assign obs_r   = XW'(obs_x) + XW'(obs_w) - XW'(1);
  assign overlap = (obs_w != 6'd0) && (obs_l <= DINO_R) && (obs_r >= DINO_L) &&
                   (y_q < YW'(obs_h));

  assign jump     = jump_q;
  assign dino_y   = y_q;
  assign collided = collided_q;
  assign airborne = (state_q == S_RISE) || (state_q == S_FALL);

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Scoreboarded bench for dino_jump_ctrl: expected values are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_dino_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn;
  logic [1:0] game_state;
  logic [9:0] obs_x;
  logic [5:0] obs_w;
  logic [5:0] obs_h;
  logic       jump;
  logic [7:0] dino_y;
  logic       airborne;
  logic       collided;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  dino_jump_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn        (btn),
    .game_state (game_state),
    .obs_x      (obs_x),
    .obs_w      (obs_w),
    .obs_h      (obs_h),
    .jump       (jump),
    .dino_y     (dino_y),
    .airborne   (airborne),
    .collided   (collided)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_jump();
    btn = 1'b0;
    cyc();
    btn = 1'b1;
    cyc();
    btn = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic set_obs(input int x, input int w, input int h);
    obs_x = 10'(x);
    obs_w = 6'(w);
    obs_h = 6'(h);
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b0; btn = 1'b0; game_state = 2'b00;
    set_obs(0, 0, 0);
    #12;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); n_vec++;
    if (32'(jump) !== e) begin n_bad++; $display("FAIL reset_jump got %0d want %0d", jump, e); end
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e) begin n_bad++; $display("FAIL reset_y got %0d want %0d", dino_y, e); end
    e = exp_q.pop_front(); n_vec++;
    if (32'(airborne) !== e) begin n_bad++; $display("FAIL reset_air got %0d want %0d", airborne, e); end
    e = exp_q.pop_front(); n_vec++;
    if (32'(collided) !== e) begin n_bad++; $display("FAIL reset_coll got %0d want %0d", collided, e); end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_jump_pulse();
    game_state = 2'b00;
    btn = 1'b0;
    cyc();
    btn = 1'b1;
    exp_q.push_back(1);
    repeat (4) exp_q.push_back(0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      e = exp_q.pop_front(); n_vec++;
      if (32'(jump) !== e) begin n_bad++; $display("FAIL pulse_jump cyc %0d got %0d want %0d", i, jump, e); end
      n_vec++;
      if (airborne !== 1'b0 || dino_y !== 8'd0) begin
        n_bad++; $display("FAIL init_ground cyc %0d air %0d y %0d want 0 0", i, airborne, dino_y);
      end
    end
    btn = 1'b0;
    cyc();
  endtask

  task automatic test_trajectory();
    game_state = 2'b10;
    start_jump();
    exp_q.push_back(1);
    e = exp_q.pop_front(); n_vec++;
    if (32'(airborne) !== e || dino_y !== 8'd0) begin
      n_bad++; $display("FAIL traj_start air %0d y %0d want %0d 0", airborne, dino_y, e);
    end
    for (int i = 1; i <= 24; i++) begin
      exp_q.push_back(32'(2 * i));
      exp_q.push_back(32'(2 * i));
      tick = 1'b1; cyc(); tick = 1'b0;
      e = exp_q.pop_front(); n_vec++;
      if (32'(dino_y) !== e) begin n_bad++; $display("FAIL traj_up tick %0d got %0d want %0d", i, dino_y, e); end
      cyc();
      e = exp_q.pop_front(); n_vec++;
      if (32'(dino_y) !== e) begin n_bad++; $display("FAIL traj_hold tick %0d got %0d want %0d", i, dino_y, e); end
    end
    n_vec++;
    if (airborne !== 1'b1) begin n_bad++; $display("FAIL traj_apex_air got %0d want 1", airborne); end
    for (int i = 1; i <= 24; i++) begin
      exp_q.push_back(32'(48 - 2 * i));
      tick = 1'b1; cyc(); tick = 1'b0;
      e = exp_q.pop_front(); n_vec++;
      if (32'(dino_y) !== e) begin n_bad++; $display("FAIL traj_down tick %0d got %0d want %0d", i, dino_y, e); end
    end
    exp_q.push_back(0);
    e = exp_q.pop_front(); n_vec++;
    if (32'(airborne) !== e) begin n_bad++; $display("FAIL traj_land_air got %0d want %0d", airborne, e); end
  endtask

  task automatic test_no_double_jump();
    game_state = 2'b10;
    start_jump();
    tick_n(5);
    exp_q.push_back(10);
    btn = 1'b1; cyc(); btn = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e || airborne !== 1'b1) begin
      n_bad++; $display("FAIL dbl_edge y %0d air %0d want %0d 1", dino_y, airborne, e);
    end
    for (int i = 6; i <= 24; i++) begin
      exp_q.push_back(32'(2 * i));
      tick = 1'b1; cyc(); tick = 1'b0;
      e = exp_q.pop_front(); n_vec++;
      if (32'(dino_y) !== e) begin n_bad++; $display("FAIL dbl_up tick %0d got %0d want %0d", i, dino_y, e); end
    end
    for (int i = 1; i <= 23; i++) begin
      exp_q.push_back(32'(48 - 2 * i));
      tick = 1'b1; cyc(); tick = 1'b0;
      e = exp_q.pop_front(); n_vec++;
      if (32'(dino_y) !== e) begin n_bad++; $display("FAIL dbl_down tick %0d got %0d want %0d", i, dino_y, e); end
    end
    // Button edge on the landing tick must not relaunch.
    exp_q.push_back(0);
    tick = 1'b1; btn = 1'b1; cyc(); tick = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e || airborne !== 1'b0) begin
      n_bad++; $display("FAIL land_edge y %0d air %0d want %0d 0", dino_y, airborne, e);
    end
    exp_q.push_back(0);
    cyc(); cyc();
    e = exp_q.pop_front(); n_vec++;
    if (32'(airborne) !== e) begin n_bad++; $display("FAIL land_relaunch air %0d want %0d", airborne, e); end
    btn = 1'b0;
    cyc();
  endtask

  task automatic test_collision();
    int tx[9] = '{59, 60, 31, 31, 40, 59, 1000, 0, 45};
    int tw[9] = '{10, 10,  9, 10,  1,  0,   63, 63,  5};
    int th[9] = '{15, 15, 15, 15,  1, 15,   63, 15,  0};
    int te[9] = '{ 1,  0,  0,  1,  1,  0,    0,  1,  0};
    game_state = 2'b10;
    for (int i = 0; i < 9; i++) begin
      set_obs(tx[i], tw[i], th[i]);
      exp_q.push_back(32'(te[i]));
      cyc();
      e = exp_q.pop_front(); n_vec++;
      if (32'(collided) !== e) begin
        n_bad++; $display("FAIL coll_x x=%0d w=%0d h=%0d got %0d want %0d", tx[i], tw[i], th[i], collided, e);
      end
    end
    set_obs(0, 0, 0);
    cyc();
  endtask

  task automatic test_collision_height();
    int th[4] = '{15, 16, 17, 17};
    int tw[4] = '{10, 10, 10,  0};
    int te[4] = '{ 0,  0,  1,  0};
    game_state = 2'b10;
    start_jump();
    tick_n(8);
    exp_q.push_back(16);
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e) begin n_bad++; $display("FAIL hgt_setup y %0d want %0d", dino_y, e); end
    for (int i = 0; i < 4; i++) begin
      set_obs(50, tw[i], th[i]);
      exp_q.push_back(32'(te[i]));
      cyc();
      e = exp_q.pop_front(); n_vec++;
      if (32'(collided) !== e) begin
        n_bad++; $display("FAIL coll_h h=%0d w=%0d got %0d want %0d", th[i], tw[i], collided, e);
      end
    end
    set_obs(0, 0, 0);
    game_state = 2'b11;
    exp_q.push_back(0);
    cyc();
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e || airborne !== 1'b0) begin
      n_bad++; $display("FAIL gs11_ground y %0d air %0d want %0d 0", dino_y, airborne, e);
    end
  endtask

  task automatic test_freeze();
    game_state = 2'b10;
    start_jump();
    tick_n(10);
    exp_q.push_back(20);
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e) begin n_bad++; $display("FAIL frz_setup y %0d want %0d", dino_y, e); end
    game_state = 2'b01;
    set_obs(45, 10, 40);
    cyc();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(20);
      exp_q.push_back(0);
      tick_n(1);
      e = exp_q.pop_front(); n_vec++;
      if (32'(dino_y) !== e || airborne !== 1'b1) begin
        n_bad++; $display("FAIL frz_y tick %0d y %0d air %0d want %0d 1", i, dino_y, airborne, e);
      end
      e = exp_q.pop_front(); n_vec++;
      if (32'(collided) !== e) begin n_bad++; $display("FAIL frz_coll tick %0d got %0d want %0d", i, collided, e); end
    end
    game_state = 2'b00;
    exp_q.push_back(0);
    cyc();
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e || airborne !== 1'b0) begin
      n_bad++; $display("FAIL init_after_dead y %0d air %0d want %0d 0", dino_y, airborne, e);
    end
    set_obs(0, 0, 0);
  endtask

  task automatic test_reset_midjump();
    game_state = 2'b10;
    set_obs(45, 10, 40);
    start_jump();
    tick_n(5);
    exp_q.push_back(10);
    exp_q.push_back(1);
    e = exp_q.pop_front(); n_vec++;
    if (32'(dino_y) !== e) begin n_bad++; $display("FAIL rmj_setup_y y %0d want %0d", dino_y, e); end
    e = exp_q.pop_front(); n_vec++;
    if (32'(collided) !== e) begin n_bad++; $display("FAIL rmj_setup_coll got %0d want %0d", collided, e); end
    btn = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({jump, dino_y, airborne, collided} !== 11'd0) begin
      n_bad++; $display("FAIL rmj_async jump %0d y %0d air %0d coll %0d want all 0", jump, dino_y, airborne, collided);
    end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(0);
      cyc();
      e = exp_q.pop_front(); n_vec++;
      if (32'(jump) !== e || airborne !== 1'b0) begin
        n_bad++; $display("FAIL held_btn cyc %0d jump %0d air %0d want %0d 0", i, jump, airborne, e);
      end
    end
    btn = 1'b0;
    cyc();
    btn = 1'b1;
    exp_q.push_back(1);
    cyc();
    e = exp_q.pop_front(); n_vec++;
    if (32'(jump) !== e || airborne !== 1'b1) begin
      n_bad++; $display("FAIL rearm jump %0d air %0d want %0d 1", jump, airborne, e);
    end
    btn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_jump_pulse();
    test_trajectory();
    test_no_double_jump();
    test_collision();
    test_collision_height();
    test_freeze();
    test_reset_midjump();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
